// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serial memory controller for instruction fetch and load/store
//
// Purpose: serialises one fetch or load/store at a time onto a byte-wide RAM.
// Loads/stores take priority over fetches; a branch flush cancels an in-flight fetch.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   rdy               global ready; 0 freezes all state
//   if_req/if_addr    fetch request (always 4 bytes)
//   if_done/if_data   fetch completion pulse and instruction word
//   mem_req/mem_we    load/store request, 1 = store
//   mem_addr/mem_len  byte address, size (00=1, 01=2, 1x=4 bytes)
//   mem_wdata         store data
//   mem_done          load/store completion pulse
//   mem_rdata         zero-extended load data
//   branch_flush      cancels an in-flight fetch
//   ram_addr/ram_wr   registered RAM address and write strobe
//   ram_dout/ram_din  RAM write byte / read byte (one cycle latency)

module mem_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [31:0] mem_addr,
   input  logic [1:0]  mem_len,
   input  logic [31:0] mem_wdata,
   output logic        mem_done,
   output logic [31:0] mem_rdata,
   input  logic        branch_flush,
   output logic [31:0] ram_addr,
   output logic        ram_wr,
   output logic [7:0]  ram_dout,
   input  logic [7:0]  ram_din
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] IF_RD  = 2'd1;
   localparam logic [1:0] MEM_RD = 2'd2;
   localparam logic [1:0] MEM_WR = 2'd3;

   logic [1:0]  state;
   logic [2:0]  cnt;        // cycles spent in the current transaction
   logic [2:0]  nbytes;
   logic [31:0] base_addr;
   logic [23:0] wdata_q;    // store bytes still to be sent, lowest first
   logic [31:0] rd_buf;

   logic        can_accept;
   logic        accept_mem;
   logic        accept_if;
   logic [2:0]  mem_nbytes;
   logic [31:0] addr_next;
   logic [31:0] rd_next;

   // A done pulse is still visible while the FSM is idle; nothing may be
   // accepted in that cycle because the requester releases req on the same edge.
   assign can_accept = (state == IDLE) && !if_done && !mem_done;
   assign accept_mem = can_accept && mem_req;
   assign accept_if  = can_accept && !mem_req && if_req && !branch_flush;

   assign mem_nbytes = (mem_len == 2'b00) ? 3'd1 :
                       (mem_len == 2'b01) ? 3'd2 : 3'd4;

   assign addr_next = base_addr + {29'd0, cnt + 3'd1};

   // ram_din in cycle cnt carries the byte addressed in cycle cnt-1.
   always_comb begin
      rd_next = rd_buf;
      case (cnt)
         3'd1:    rd_next[7:0]   = ram_din;
         3'd2:    rd_next[15:8]  = ram_din;
         3'd3:    rd_next[23:16] = ram_din;
         3'd4:    rd_next[31:24] = ram_din;
         default: rd_next = rd_buf;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= 3'd0;
         nbytes    <= 3'd0;
         base_addr <= 32'd0;
         wdata_q   <= 24'd0;
         rd_buf    <= 32'd0;
         if_done   <= 1'b0;
         if_data   <= 32'd0;
         mem_done  <= 1'b0;
         mem_rdata <= 32'd0;
         ram_addr  <= 32'd0;
         ram_wr    <= 1'b0;
         ram_dout  <= 8'd0;
      end else if (rdy) begin
         if_done  <= 1'b0;
         mem_done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept_mem) begin
                  base_addr <= mem_addr;
                  ram_addr  <= mem_addr;
                  nbytes    <= mem_nbytes;
                  cnt       <= 3'd0;
                  rd_buf    <= 32'd0;
                  if (mem_we) begin
                     state    <= MEM_WR;
                     ram_wr   <= 1'b1;
                     ram_dout <= mem_wdata[7:0];
                     wdata_q  <= mem_wdata[31:8];
                  end else begin
                     state <= MEM_RD;
                  end
               end else if (accept_if) begin
                  base_addr <= if_addr;
                  ram_addr  <= if_addr;
                  nbytes    <= 3'd4;
                  cnt       <= 3'd0;
                  rd_buf    <= 32'd0;
                  state     <= IF_RD;
               end
            end
            IF_RD, MEM_RD: begin
               if (state == IF_RD && branch_flush) begin
                  state    <= IDLE;
                  ram_addr <= 32'd0;
                  cnt      <= 3'd0;
               end else begin
                  if (cnt != 3'd0)
                     rd_buf <= rd_next;
                  if (cnt == nbytes) begin
                     state    <= IDLE;
                     ram_addr <= 32'd0;
                     cnt      <= 3'd0;
                     if (state == IF_RD) begin
                        if_done <= 1'b1;
                        if_data <= rd_next;
                     end else begin
                        mem_done  <= 1'b1;
                        mem_rdata <= rd_next;
                     end
                  end else begin
                     cnt <= cnt + 3'd1;
                     // Last address stays on the bus while its byte returns.
                     if (cnt + 3'd1 < nbytes)
                        ram_addr <= addr_next;
                  end
               end
            end
            MEM_WR: begin
               if (cnt == nbytes - 3'd1) begin
                  state    <= IDLE;
                  ram_wr   <= 1'b0;
                  ram_addr <= 32'd0;
                  ram_dout <= 8'd0;
                  cnt      <= 3'd0;
                  mem_done <= 1'b1;
               end else begin
                  cnt      <= cnt + 3'd1;
                  ram_addr <= addr_next;
                  ram_dout <= wdata_q[7:0];
                  wdata_q  <= {8'd0, wdata_q[23:8]};
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb/tb_mem_ctrl.sv - directed self-checking bench for mem_ctrl

module tb_mem_ctrl;

   logic        clk;
   logic        rst;
   logic        rdy;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_done;
   logic [31:0] if_data;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [1:0]  mem_len;
   logic [31:0] mem_wdata;
   logic        mem_done;
   logic [31:0] mem_rdata;
   logic        branch_flush;
   logic [31:0] ram_addr;
   logic        ram_wr;
   logic [7:0]  ram_dout;
   logic [7:0]  ram_din;

   int total = 0;
   int bad   = 0;
   int both_cnt = 0;

   logic [7:0]  init_mem [0:65535];
   logic [31:0] wa [0:63];
   logic [7:0]  wd [0:63];
   logic [5:0]  wn = 6'd0;
   logic [5:0]  w0;

   mem_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .rdy          (rdy),
      .if_req       (if_req),
      .if_addr      (if_addr),
      .if_done      (if_done),
      .if_data      (if_data),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_len      (mem_len),
      .mem_wdata    (mem_wdata),
      .mem_done     (mem_done),
      .mem_rdata    (mem_rdata),
      .branch_flush (branch_flush),
      .ram_addr     (ram_addr),
      .ram_wr       (ram_wr),
      .ram_dout     (ram_dout),
      .ram_din      (ram_din)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: one-cycle read latency, frozen together with the system by rdy.
   always @(posedge clk) begin
      if (rdy) begin
         ram_din <= init_mem[ram_addr[15:0]];
         if (ram_wr) begin
            wa[wn] <= ram_addr;
            wd[wn] <= ram_dout;
            wn     <= wn + 6'd1;
         end
      end
   end

   always @(negedge clk)
      if (if_done && mem_done)
         both_cnt <= both_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v)
      else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; rdy = 1'b1;
      if_req = 1'b0; if_addr = 32'd0;
      mem_req = 1'b0; mem_we = 1'b0; mem_addr = 32'd0; mem_len = 2'd0; mem_wdata = 32'd0;
      branch_flush = 1'b0;
      for (int i = 0; i < 65536; i++) init_mem[i] = 8'h00;
      init_mem[16'h0100] = 8'h13; init_mem[16'h0101] = 8'h05;
      init_mem[16'h0102] = 8'hA0; init_mem[16'h0103] = 8'h00;
      init_mem[16'h0200] = 8'h11; init_mem[16'h0201] = 8'h22;
      init_mem[16'h0202] = 8'h33; init_mem[16'h0203] = 8'h44;
      init_mem[16'h2000] = 8'hFF;
      init_mem[16'h0300] = 8'h99;

      // Reset state, before any clock edge
      #1;
      chk("rst_ram_addr", ram_addr, 32'd0);
      chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
      chk("rst_ram_dout", {24'd0, ram_dout}, 32'd0);
      chk("rst_if_done", {31'd0, if_done}, 32'd0);
      chk("rst_mem_done", {31'd0, mem_done}, 32'd0);
      chk("rst_if_data", if_data, 32'd0);
      chk("rst_mem_rdata", mem_rdata, 32'd0);
      step(); step();
      rst = 1'b0;

      // Word fetch with address change after acceptance
      if_req = 1'b1; if_addr = 32'h100;
      step();
      chk("f1_addr0", ram_addr, 32'h100);
      chk("f1_wr0", {31'd0, ram_wr}, 32'd0);
      if_addr = 32'hDEADBEEF;
      step(); chk("f1_addr1", ram_addr, 32'h101);
      step(); chk("f1_addr2", ram_addr, 32'h102);
      step(); chk("f1_addr3", ram_addr, 32'h103);
      step(); chk("f1_done_early", {31'd0, if_done}, 32'd0);
      step();
      chk("f1_done", {31'd0, if_done}, 32'd1);
      chk("f1_data", if_data, 32'h00A00513);
      chk("f1_memdone", {31'd0, mem_done}, 32'd0);
      if_req = 1'b0;
      step();
      chk("f1_done_end", {31'd0, if_done}, 32'd0);
      chk("f1_idle_addr", ram_addr, 32'd0);

      // Contention: byte load wins, fetch follows one cycle after mem_done
      if_req = 1'b1; if_addr = 32'h200;
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b00; mem_addr = 32'h2000;
      step(); chk("c_addr", ram_addr, 32'h2000);
      step();
      step();
      chk("c_memdone", {31'd0, mem_done}, 32'd1);
      chk("c_rdata", mem_rdata, 32'h000000FF);
      chk("c_ifdone", {31'd0, if_done}, 32'd0);
      mem_req = 1'b0;
      step();
      chk("c_memdone_end", {31'd0, mem_done}, 32'd0);
      chk("c_no_accept", ram_addr, 32'd0);
      step(); chk("c_fetch_addr", ram_addr, 32'h200);
      step(); step(); step(); step();
      step();
      chk("c_fetch_done", {31'd0, if_done}, 32'd1);
      chk("c_fetch_data", if_data, 32'h44332211);
      if_req = 1'b0;
      step();

      // Half-word store crossing into 0x2000 boundary
      w0 = wn;
      mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b01; mem_addr = 32'h1FFE; mem_wdata = 32'h12345678;
      step();
      chk("s_wr0", {31'd0, ram_wr}, 32'd1);
      chk("s_addr0", ram_addr, 32'h1FFE);
      chk("s_dout0", {24'd0, ram_dout}, 32'h78);
      chk("s_done0", {31'd0, mem_done}, 32'd0);
      step();
      chk("s_wr1", {31'd0, ram_wr}, 32'd1);
      chk("s_addr1", ram_addr, 32'h1FFF);
      chk("s_dout1", {24'd0, ram_dout}, 32'h56);
      step();
      chk("s_done", {31'd0, mem_done}, 32'd1);
      chk("s_wr_off", {31'd0, ram_wr}, 32'd0);
      mem_req = 1'b0; mem_we = 1'b0;
      step();
      chk("s_nwrites", {26'd0, wn - w0}, 32'd2);
      chk("s_log_a0", wa[w0], 32'h1FFE);
      chk("s_log_d0", {24'd0, wd[w0]}, 32'h78);
      chk("s_log_a1", wa[w0 + 6'd1], 32'h1FFF);
      chk("s_log_d1", {24'd0, wd[w0 + 6'd1]}, 32'h56);

      // Flush mid-fetch; flush also blocks acceptance while idle
      if_req = 1'b1; if_addr = 32'h300;
      step(); chk("fl_addr0", ram_addr, 32'h300);
      step();
      branch_flush = 1'b1; if_addr = 32'h100;
      step();
      chk("fl_idle", ram_addr, 32'd0);
      chk("fl_no_done", {31'd0, if_done}, 32'd0);
      step();
      chk("fl_blocked", ram_addr, 32'd0);
      branch_flush = 1'b0;
      step(); chk("fl_new_addr", ram_addr, 32'h100);
      step(); step(); step(); step();
      chk("fl_done_early", {31'd0, if_done}, 32'd0);
      step();
      chk("fl_done", {31'd0, if_done}, 32'd1);
      chk("fl_data", if_data, 32'h00A00513);
      if_req = 1'b0;
      step();

      // Word load stalled by rdy=0 for three cycles
      mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h200;
      step(); chk("st_addr0", ram_addr, 32'h200);
      step(); chk("st_addr1", ram_addr, 32'h201);
      rdy = 1'b0;
      step(); chk("st_frz1", ram_addr, 32'h201);
      step(); chk("st_frz2", ram_addr, 32'h201);
      step(); chk("st_frz3", ram_addr, 32'h201);
      rdy = 1'b1;
      step(); chk("st_addr2", ram_addr, 32'h202);
      step();
      step(); chk("st_done_early", {31'd0, mem_done}, 32'd0);
      step();
      chk("st_done", {31'd0, mem_done}, 32'd1);
      chk("st_data", mem_rdata, 32'h44332211);
      mem_req = 1'b0;
      step();

      // Reset pulse during store byte 1, then fetch on first edge after release
      w0 = wn;
      mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h400; mem_wdata = 32'hAABBCCDD;
      step();
      chk("r_wr0", {31'd0, ram_wr}, 32'd1);
      chk("r_dout0", {24'd0, ram_dout}, 32'hDD);
      step();
      chk("r_addr1", ram_addr, 32'h401);
      chk("r_dout1", {24'd0, ram_dout}, 32'hCC);
      #2;
      rst = 1'b1; mem_req = 1'b0; mem_we = 1'b0;
      #1;
      chk("r_wr_async", {31'd0, ram_wr}, 32'd0);
      chk("r_addr_async", ram_addr, 32'd0);
      chk("r_dout_async", {24'd0, ram_dout}, 32'd0);
      #2;
      rst = 1'b0;
      if_req = 1'b1; if_addr = 32'h100;
      step();
      chk("r_first_accept", ram_addr, 32'h100);
      chk("r_wr_after", {31'd0, ram_wr}, 32'd0);
      step(); step(); step(); step();
      chk("r_no_memdone", {31'd0, mem_done}, 32'd0);
      step();
      chk("r_fetch_done", {31'd0, if_done}, 32'd1);
      chk("r_fetch_data", if_data, 32'h00A00513);
      if_req = 1'b0;
      step();
      chk("r_nwrites", {26'd0, wn - w0}, 32'd1);
      chk("r_log_a0", wa[w0], 32'h400);

      chk("both_done", both_cnt, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 SHALL provide ports (name  direction  width  meaning):
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global ready; 0 freezes all state
- if_req  in  1  fetch request, held until if_done
- if_addr  in  32  fetch byte address
- if_done  out  1  fetch complete pulse
- if_data  out  32  fetched instruction, valid while if_done=1
- mem_req  in  1  load/store request, held until mem_done
- mem_we  in  1  1=store, 0=load
- mem_addr  in  32  load/store byte address
- mem_len  in  2  00=1 byte, 01=2 bytes, 10/11=4 bytes
- mem_wdata  in  32  store data
- mem_done  out  1  load/store complete pulse
- mem_rdata  out  32  load data, zero-extended, valid while mem_done=1
- branch_flush  in  1  pipeline redirect from ex; cancels fetch
- ram_addr  out  32  RAM byte address (registered)
- ram_wr  out  1  RAM write strobe (registered)
- ram_dout  out  8  RAM write byte (registered)
- ram_din  in  8  RAM read byte, valid one cycle after ram_addr presented
REQ-002 Reset SHALL be asynchronous and active-high on port rst; single clock clk.

Function
REQ-003 SHALL implement FSM states IDLE, IF_RD, MEM_RD, MEM_WR; one transaction in flight.
REQ-004 In IDLE, with rdy=1 and if_done=0 and mem_done=0, SHALL accept mem_req over if_req when both high (mem priority).
REQ-005 SHALL NOT accept if_req in a cycle where branch_flush=1.
REQ-006 Request fields SHALL be latched at acceptance edge; later input changes ignored.
REQ-007 Byte count N: 1/2/4 per mem_len; fetches always N=4.
REQ-008 Accept at end of cycle T: byte k (k=0..N-1) SHALL be on ram_addr = addr+k during cycle T+1+k; addition modulo 2^32.
REQ-009 Reads: ram_wr=0; byte k SHALL be sampled from ram_din at end of cycle T+2+k into bits [8k+7:8k] (little-endian); unused upper bits 0.
REQ-010 Reads: done SHALL be 1 for exactly cycle T+N+2 (word read: T+6), with data valid that cycle.
REQ-011 Writes: ram_wr=1 and ram_dout = mem_wdata[8k+7:8k] during cycle T+1+k; mem_done SHALL be 1 for exactly cycle T+N+1.
REQ-012 Outside active write cycles ram_wr SHALL be 0; in IDLE ram_addr SHALL be 0.
REQ-013 FSM SHALL be in IDLE during the done cycle; no acceptance that cycle (requester drops req on same edge).
REQ-014 branch_flush=1 during any IF_RD cycle SHALL return FSM to IDLE next edge; if_done not asserted for that fetch; no RAM write occurs.
REQ-015 branch_flush SHALL NOT affect MEM_RD or MEM_WR; stores never aborted.
REQ-016 rdy=0 SHALL hold every register (state, counter, outputs, done pulse extends) until rdy=1.
REQ-017 if_done and mem_done SHALL never be 1 in the same cycle.

Reset
REQ-018 On rst=1, immediately and regardless of clk: state IDLE, counters 0, all outputs 0 (ram_wr=0, if_done=0, mem_done=0, ram_addr=0, ram_dout=0, if_data=0, mem_rdata=0).
REQ-019 rst mid-transaction SHALL abandon it; no done pulse after release; ram_wr=0 during and after reset.
REQ-020 First acceptance possible in first clk edge after rst deasserts.

Verification
REQ-021 Fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,A0,00 -> ram_addr 0x100..0x103 in T+1..T+4, if_done=1 in T+6, if_data=0x00A00513.
REQ-022 Contention: if_req and mem_req (load, len=00, addr=0x2000, RAM=0xFF) same cycle -> load first, mem_done with mem_rdata=0x000000FF, fetch accepted the cycle after mem_done.
REQ-023 Store half: mem_we=1, len=01, addr=0x1FFE, wdata=0x12345678 -> ram_wr=1 two cycles, bytes 78@0x1FFE, 56@0x1FFF; mem_done at T+3; RAM[0x2000] unchanged.
REQ-024 Flush: fetch accepted, branch_flush=1 in T+2 -> IDLE at T+3, no if_done; new fetch with new address completes normally.
REQ-025 rdy=0 for 3 cycles mid-word-read -> ram_addr frozen, completion delayed exactly 3 cycles, data correct.
REQ-026 rst pulse (between edges) during store byte 1 -> ram_wr=0 immediately, no mem_done, byte 2..3 never written.
